aha_sram_initiator: RTL and testbench

AHA_SRAM_INITIATOR -- requirements
Module: aha_sram_initiator

---
 rtl/aha_sram_pkg.sv | 17 +
 rtl/aha_sram_rsp_fifo.sv | 53 +++++
 rtl/aha_sram_initiator.sv | 146 ++++++++++++++
 tb/tb_aha_sram_initiator.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aha_sram_pkg.sv
// rtl/aha_sram_pkg.sv - shared types and default widths for the SRAM initiator
package aha_sram_pkg;

  // Default macro geometry
  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 32;

  // Response FIFO depth; bounds the number of reads that may be outstanding
  localparam int RSP_DEPTH = 2;

  // Controller top-level state: zero-fill sweep, then normal request service
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/aha_sram_rsp_fifo.sv
// rtl/aha_sram_rsp_fifo.sv - two-entry read response FIFO with occupancy count
module aha_sram_rsp_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         pop_ok;
  logic         push_ok;

  // A pop only counts when something is stored; a push is refused only when
  // full and not draining in the same cycle.
  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'd2) || pop_ok);

  assign valid = (count != 2'd0);
  assign data  = mem[rd_ptr];

  // Storage, pointers and occupancy; simultaneous push/pop leaves count as is
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aha_sram_initiator.sv
// rtl/aha_sram_initiator.sv - request/response front end for a single-port SRAM macro
module aha_sram_initiator
  import aha_sram_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic                REQ_VALID,
  output logic                REQ_READY,
  input  logic                REQ_WRITE,
  input  logic [ADDR_W-1:0]   REQ_ADDR,
  input  logic [DATA_W/8-1:0] REQ_WSTRB,
  input  logic [DATA_W-1:0]   REQ_WDATA,
  output logic                RSP_VALID,
  input  logic                RSP_READY,
  output logic [DATA_W-1:0]   RSP_RDATA,
  output logic                INIT_DONE,
  output logic                SRAM_CEn,
  output logic [DATA_W/8-1:0] SRAM_WEn,
  output logic [ADDR_W-1:0]   SRAM_A,
  output logic [DATA_W-1:0]   SRAM_D,
  input  logic [DATA_W-1:0]   SRAM_Q
);

  localparam int STRB_W = DATA_W / 8;

  state_e            state;
  state_e            state_nxt;
  logic [ADDR_W-1:0] init_addr;
  logic              init_last;
  logic              in_flight;
  logic [ADDR_W-1:0] last_a;
  logic [DATA_W-1:0] last_d;
  logic [1:0]        fifo_count;
  logic              fifo_valid;
  logic              rsp_pop;
  logic [2:0]        pending;
  logic              req_fire;
  logic              rd_fire;
  logic              wr_access;

  assign init_last = (init_addr == {ADDR_W{1'b1}});

  // Reads already issued but not yet consumed, less the one leaving this cycle.
  // Popping this cycle frees a slot immediately, hence RSP_READY -> REQ_READY.
  assign rsp_pop = fifo_valid && RSP_READY;
  assign pending = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, rsp_pop};

  // RESETn gates the combinational outputs so they show idle values while held
  assign REQ_READY = RESETn && (state == RUN) && (pending < 3'd2);
  assign INIT_DONE = RESETn && (state == RUN);

  assign req_fire  = REQ_VALID && REQ_READY;
  assign rd_fire   = req_fire && !REQ_WRITE;
  // A write with no byte enabled is consumed without touching the macro
  assign wr_access = req_fire && REQ_WRITE && (|REQ_WSTRB);

  // INIT leaves once the last address has been written
  always_comb begin
    state_nxt = state;
    if ((state == INIT) && init_last) begin
      state_nxt = RUN;
    end
  end

  // State register; reset lands in INIT or RUN depending on the fill option
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= INIT_ON_RESET ? INIT : RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Zero-fill address sweep, one word per cycle while in INIT
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      init_addr <= '0;
    end else if (state == INIT) begin
      init_addr <= init_addr + ADDR_W'(1);
    end
  end

  // Macro pin drive: init fill, accepted write, accepted read, else idle hold
  always_comb begin
    SRAM_CEn = 1'b1;
    SRAM_WEn = {STRB_W{1'b1}};
    SRAM_A   = last_a;
    SRAM_D   = last_d;
    if (RESETn) begin
      if (state == INIT) begin
        SRAM_CEn = 1'b0;
        SRAM_WEn = '0;
        SRAM_A   = init_addr;
        SRAM_D   = '0;
      end else if (wr_access) begin
        SRAM_CEn = 1'b0;
        SRAM_WEn = ~REQ_WSTRB;
        SRAM_A   = REQ_ADDR;
        SRAM_D   = REQ_WDATA;
      end else if (rd_fire) begin
        SRAM_CEn = 1'b0;
        SRAM_A   = REQ_ADDR;
      end
    end
  end

  // Remember the last driven address/data so idle cycles hold the bus steady
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      last_a <= '0;
      last_d <= '0;
    end else if (!SRAM_CEn) begin
      last_a <= SRAM_A;
      last_d <= SRAM_D;
    end
  end

  // A read issued this cycle has its data on SRAM_Q during the next one
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      in_flight <= 1'b0;
    end else begin
      in_flight <= rd_fire;
    end
  end

  aha_sram_rsp_fifo #(
    .W (DATA_W)
  ) u_rsp_fifo (
    .clk       (CLK),
    .rst_n     (RESETn),
    .push      (in_flight),
    .push_data (SRAM_Q),
    .pop       (rsp_pop),
    .valid     (fifo_valid),
    .data      (RSP_RDATA),
    .count     (fifo_count)
  );

  assign RSP_VALID = fifo_valid;

endmodule

// File: tb/tb_aha_sram_initiator.sv
// tb/tb_aha_sram_initiator.sv - randomized self-checking bench for aha_sram_initiator
module tb_aha_sram_initiator;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic        REQ_WRITE = 1'b0;
  logic [3:0]  REQ_ADDR = '0;
  logic [3:0]  REQ_WSTRB = '0;
  logic [31:0] REQ_WDATA = '0;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b0;
  logic [31:0] RSP_RDATA;
  logic        INIT_DONE;
  logic        SRAM_CEn;
  logic [3:0]  SRAM_WEn;
  logic [3:0]  SRAM_A;
  logic [31:0] SRAM_D;
  logic [31:0] SRAM_Q = '0;

  int n_tests = 0;
  int n_fail  = 0;

  aha_sram_initiator #(
    .ADDR_W        (4),
    .DATA_W        (32),
    .INIT_ON_RESET (1'b1)
  ) dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_WRITE (REQ_WRITE),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WSTRB (REQ_WSTRB),
    .REQ_WDATA (REQ_WDATA),
    .RSP_VALID (RSP_VALID),
    .RSP_READY (RSP_READY),
    .RSP_RDATA (RSP_RDATA),
    .INIT_DONE (INIT_DONE),
    .SRAM_CEn  (SRAM_CEn),
    .SRAM_WEn  (SRAM_WEn),
    .SRAM_A    (SRAM_A),
    .SRAM_D    (SRAM_D),
    .SRAM_Q    (SRAM_Q)
  );

  always #5 CLK = ~CLK;

  // Behavioural macro: byte-masked writes, registered read data
  logic [31:0] sram_mem [16];
  always @(posedge CLK) begin
    if (!SRAM_CEn) begin
      if (&SRAM_WEn) begin
        SRAM_Q <= sram_mem[SRAM_A];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (!SRAM_WEn[b]) sram_mem[SRAM_A][b*8 +: 8] <= SRAM_D[b*8 +: 8];
        end
      end
    end
  end

  // Reference model: memory image, queue of outstanding reads, last bus values
  typedef struct {
    logic [31:0] data;
    int          acc;
  } rd_t;
  rd_t         rq[$];
  logic [31:0] ref_mem [16];
  logic [3:0]  m_last_a;
  logic [31:0] m_last_d;
  bit          d_known;
  int          cyc = 0;

  logic        obs_ready;
  logic        obs_valid;
  logic [31:0] obs_rdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_values();
    check("rst_pins", {SRAM_CEn, SRAM_WEn, SRAM_A, SRAM_D}, {1'b1, 4'hF, 4'h0, 32'h0});
    check("rst_rsp_valid", RSP_VALID, 0);
    check("rst_rsp_rdata", RSP_RDATA, 0);
    check("rst_req_ready", REQ_READY, 0);
    check("rst_init_done", INIT_DONE, 0);
  endtask

  // Called at posedge+1 of the first fill cycle; checks `upto` fill writes
  task automatic init_check(input int upto);
    for (int i = 0; i < upto; i++) begin
      REQ_VALID = 1'(i % 2);
      #4;
      check("init_pins", {SRAM_CEn, SRAM_WEn, SRAM_A, SRAM_D}, {1'b0, 4'h0, 4'(i), 32'h0});
      check("init_ready", REQ_READY, 0);
      check("init_done", INIT_DONE, 0);
      @(posedge CLK);
      #1;
    end
    REQ_VALID = 1'b0;
  endtask

  // One request-interface cycle, entered and left at posedge+1
  task automatic cycle(input logic v, input logic w, input logic [3:0] a,
                       input logic [3:0] s, input logic [31:0] d, input logic rr);
    int   outstanding;
    logic exp_valid;
    logic exp_ready;
    logic pop;
    logic fire;
    REQ_VALID = v;
    REQ_WRITE = w;
    REQ_ADDR  = a;
    REQ_WSTRB = s;
    REQ_WDATA = d;
    RSP_READY = rr;
    #4;
    outstanding = rq.size();
    exp_valid   = (outstanding > 0) && (rq[0].acc <= cyc - 2);
    pop         = exp_valid && rr;
    exp_ready   = (outstanding - (pop ? 1 : 0)) < 2;
    fire        = v && exp_ready;
    check("req_ready", REQ_READY, exp_ready);
    check("rsp_valid", RSP_VALID, exp_valid);
    if (exp_valid) check("rsp_rdata", RSP_RDATA, rq[0].data);
    if (fire && w && (s != 4'h0)) begin
      check("pins_write", {SRAM_CEn, SRAM_WEn, SRAM_A, SRAM_D}, {1'b0, ~s, a, d});
    end else if (fire && !w) begin
      check("pins_read", {SRAM_CEn, SRAM_WEn, SRAM_A}, {1'b0, 4'hF, a});
    end else if (d_known) begin
      check("pins_idle", {SRAM_CEn, SRAM_WEn, SRAM_A, SRAM_D}, {1'b1, 4'hF, m_last_a, m_last_d});
    end else begin
      check("pins_idle", {SRAM_CEn, SRAM_WEn, SRAM_A}, {1'b1, 4'hF, m_last_a});
    end
    obs_ready = REQ_READY;
    obs_valid = RSP_VALID;
    obs_rdata = RSP_RDATA;
    @(posedge CLK);
    if (pop) void'(rq.pop_front());
    if (fire && w && (s != 4'h0)) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
      end
      m_last_a = a;
      m_last_d = d;
      d_known  = 1'b1;
    end else if (fire && !w) begin
      rq.push_back('{data: ref_mem[a], acc: cyc});
      m_last_a = a;
      d_known  = 1'b0;
    end
    cyc++;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          idx;
    logic [3:0]  addr3 [3];
    addr3[0] = 4'd1;
    addr3[1] = 4'd2;
    addr3[2] = 4'd3;

    // Reset values, then a fill interrupted at address 7
    repeat (2) @(posedge CLK);
    #1;
    reset_values();
    RESETn = 1'b1;
    init_check(7);
    #4;
    check("init_a7", SRAM_A, 4'd7);
    RESETn = 1'b0;
    #1;
    reset_values();
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESETn = 1'b1;

    // Full fill restarting from address 0; done in the 17th cycle
    init_check(16);
    #4;
    check("init_done_17", INIT_DONE, 1);
    check("post_init_pins", {SRAM_CEn, SRAM_WEn, SRAM_A, SRAM_D}, {1'b1, 4'hF, 4'hF, 32'h0});
    check("post_init_ready", REQ_READY, 1);
    @(posedge CLK);
    #1;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    m_last_a = 4'hF;
    m_last_d = 32'h0;
    d_known  = 1'b1;

    // Full write then read-back with latency 2
    cycle(1, 1, 4'd5, 4'hF, 32'hDEADBEEF, 1);
    cycle(1, 0, 4'd5, 4'h0, 32'h0, 1);
    cycle(0, 0, 4'd0, 4'h0, 32'h0, 1);
    check("rd_lat_n1", obs_valid, 0);
    cycle(0, 0, 4'd0, 4'h0, 32'h0, 1);
    check("rd_lat_n2", obs_valid, 1);
    check("rd_full", obs_rdata, 32'hDEADBEEF);

    // Partial byte write merges into the existing word
    cycle(1, 1, 4'd5, 4'h2, 32'h0000AA00, 1);
    cycle(1, 0, 4'd5, 4'h0, 32'h0, 1);
    cycle(0, 0, 4'd0, 4'h0, 32'h0, 1);
    cycle(0, 0, 4'd0, 4'h0, 32'h0, 1);
    check("rd_partial", obs_rdata, 32'hDEADAAEF);

    // Zero-strobe write leaves the word untouched
    cycle(1, 1, 4'd5, 4'h0, 32'h12345678, 1);
    cycle(1, 0, 4'd5, 4'h0, 32'h0, 1);
    cycle(0, 0, 4'd0, 4'h0, 32'h0, 1);
    cycle(0, 0, 4'd0, 4'h0, 32'h0, 1);
    check("rd_nostrb", obs_rdata, 32'hDEADAAEF);

    // Back-to-back reads of 1..4 with the consumer always ready
    for (int k = 1; k <= 4; k++) cycle(1, 1, 4'(k), 4'hF, 32'h11111111 * k, 1);
    for (int k = 0; k < 6; k++) begin
      cycle(k < 4, 0, 4'(k + 1), 4'h0, 32'h0, 1);
      if (k < 4) check("b2b_ready", obs_ready, 1);
      if (k >= 2) begin
        check("b2b_valid", obs_valid, 1);
        check("b2b_data", obs_rdata, 32'h11111111 * (k - 1));
      end
    end

    // Stalled consumer: only two reads accepted until the first pops
    idx = 0;
    for (int t = 0; t < 6; t++) begin
      cycle(1, 0, addr3[idx], 4'h0, 32'h0, 0);
      if (obs_ready && idx < 2) idx++;
    end
    check("stall_accepted", idx, 2);
    check("stall_ready", obs_ready, 0);
    cycle(1, 0, addr3[2], 4'h0, 32'h0, 1);
    check("stall_release_ready", obs_ready, 1);
    check("stall_release_valid", obs_valid, 1);
    check("stall_release_data", obs_rdata, 32'h11111111);
    for (int t = 0; t < 6; t++) cycle(0, 0, 4'd0, 4'h0, 32'h0, 1);

    // Randomized traffic against the reference model
    for (int t = 0; t < 400; t++) begin
      cycle(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 9) < 6));
    end
    for (int t = 0; t < 8; t++) cycle(0, 0, 4'd0, 4'h0, 32'h0, 1);
    check("drain_empty", rq.size(), 0);
    check("drain_rsp_valid", RSP_VALID, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
